mcontrol_fsm: RTL and testbench
===============================

Name: mcontrol_fsm

Overview:
Multicycle main control unit for the MIPS-subset datapath. It sits directly upstream of the ALU control block and drives its aluop2/aluop1/aluop0 inputs. It sequences fetch/decode/execute/memory/writeback per opcode, stalls on a memory-ready handshake, and drives all datapath enables. It also implements the custom blezal (branch-if-≤0 and link) and brv (branch to register value) flows.

Parameters:
LINK_REG, 5'd31, register index driven on link_rd during the blezal link writeback

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
op  in  6  opcode field of the instruction register
zero  in  1  ALU zero flag
alu_neg  in  1  ALU result sign bit
mem_ready  in  1  memory transfer complete this cycle
pcen  out  1  PC load enable, already qualified
iord  out  1  0 = PC address, 1 = ALUOut address
memread  out  1  memory read strobe
memwrite  out  1  memory write strobe
irwrite  out  1  instruction register load
memtoreg  out  1  writeback source is MDR
regdst  out  1  1 = rd, 0 = rt
link  out  1  write PC+4 to link_rd
link_rd  out  5  = LINK_REG
regwrite  out  1  register file write
alusrca  out  1  0 = PC, 1 = A
alusrcb  out  2  00 = B, 01 = 4, 10 = signext imm, 11 = imm<<2
pcsource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target, 11 = A register
aluop2, aluop1, aluop0  out  1 each  to ALU control
illegal  out  1  one-cycle pulse on an unknown opcode
state  out  4  current state, for debug

Behaviour:
- Moore decode of the state register. The only Mealy terms are mem_ready in the wait states and zero/alu_neg in pcen.
- While reset=1: next state is FETCH, all outputs 0, and taken_q is cleared. Reset dominates every other event, mid-instruction included. The first cycle after reset is FETCH.
- Opcodes: R = 000000, lw = 100011, sw = 101011, beq = 000100, j = 000010, imm-op = 001101, blezal = 010110, brv = 010100.
- aluop encoding: 000 = add, 001 = branch subtract, 011 = imm-op, 100 = R-type (function decode), 111 = brv.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=000, pcsource=00.
  - irwrite and pcen equal mem_ready.
  - Stay in FETCH while mem_ready=0. Go to DECODE when mem_ready=1.
- DECODE: alusrca=0, alusrcb=11, aluop=000 (branch target into ALUOut). Next state by op:
  - lw/sw → MEMADR; R → RTEXEC; imm-op → ITEXEC; beq → BEQ; blezal → BLEZ; brv → BRV; j → JUMP.
  - Any other opcode → FETCH, with illegal=1 for this cycle only.
- MEMADR: alusrca=1, alusrcb=10, aluop=000. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: memread=1, iord=1. Wait for mem_ready, then MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. Next FETCH.
- MEMWR: memwrite=1, iord=1. Wait for mem_ready, then FETCH. memwrite is held for the whole wait.
- RTEXEC: alusrca=1, alusrcb=00, aluop=100. Next RTWB.
- RTWB: regwrite=1, regdst=1, memtoreg=0. Next FETCH.
- ITEXEC: alusrca=1, alusrcb=10, aluop=011. Next ITWB.
- ITWB: regwrite=1, regdst=0, memtoreg=0. Next FETCH.
- BEQ: alusrca=1, alusrcb=00, aluop=001, pcsource=01, pcen=zero. Next FETCH.
- BLEZ: same datapath settings as BEQ, with pcen=(zero|alu_neg).
  - taken_q captures (zero|alu_neg) at the end of the cycle.
  - Next is LINK if taken, else FETCH.
- LINK: regwrite=1, link=1. Next FETCH. The register file is written only in LINK, so an untaken blezal never links.
- BRV: alusrca=1, alusrcb=00, aluop=111, pcsource=11, pcen=1 (unconditional). Next FETCH.
- JUMP: pcsource=10, pcen=1. Next FETCH.
- Cycle counts (mem_ready held at 1):
  - lw 5; sw 4; R 4; imm-op 4; beq 3; j 3; brv 3.
  - blezal 4 if taken, 3 if not.
  - Every mem_ready=0 cycle adds one cycle.
- Unused state encodings → FETCH with all outputs 0.
- Strobes (regwrite, memwrite, pcen) are never asserted for more than one cycle, except memwrite/memread held during a mem_ready wait.

Decomposition:
- Shared package mcontrol_pkg holds: opcode constants, aluop encodings, alusrcb/pcsource codes, and the 4-bit state enum.
- One natural sub-module, mcontrol_outdec: purely combinational decode from state (plus mem_ready, zero, alu_neg, taken_q) to outputs.
- The state register, next-state logic and taken_q stay in mcontrol_fsm.

Test Plan:
- Reset, then lw with mem_ready low for 2 cycles in FETCH and 1 in MEMRD → state path FETCH(x3)-DECODE-MEMADR-MEMRD(x2)-MEMWB-FETCH; irwrite/pcen high only on the third FETCH cycle; regwrite=1, memtoreg=1 in MEMWB.
- R-type (op=000000), mem_ready=1 → aluop=100 in RTEXEC; regwrite=1, regdst=1 in RTWB; 4 cycles total.
- blezal with zero=0, alu_neg=1 in BLEZ → pcen=1, next LINK with regwrite=1, link=1, link_rd=31. Repeat with zero=0, alu_neg=0 → pcen=0, no LINK, back to FETCH.
- brv (op=010100) → aluop=111, pcsource=11, pcen=1 in BRV. beq with zero=0 → pcen=0.
- op=111111 → illegal=1 for exactly one cycle in DECODE, then FETCH, no other strobes asserted.
- reset=1 asserted while in MEMWR with mem_ready=0 → memwrite=0 that cycle and all outputs 0; FETCH on the first cycle after reset drops.

Source files
------------

// File: rtl/mcontrol_pkg.sv
// Shared encodings for the multicycle main control unit: opcodes, ALU-op codes,
// mux select codes and the controller state enum.
package mcontrol_pkg;

  localparam logic [5:0] OP_R      = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_IMM    = 6'b001101;
  localparam logic [5:0] OP_BLEZAL = 6'b010110;
  localparam logic [5:0] OP_BRV    = 6'b010100;

  localparam logic [2:0] ALUOP_ADD = 3'b000;
  localparam logic [2:0] ALUOP_SUB = 3'b001;
  localparam logic [2:0] ALUOP_IMM = 3'b011;
  localparam logic [2:0] ALUOP_RT  = 3'b100;
  localparam logic [2:0] ALUOP_BRV = 3'b111;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_A      = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_RTWB   = 4'd7,
    S_ITEXEC = 4'd8,
    S_ITWB   = 4'd9,
    S_BEQ    = 4'd10,
    S_BLEZ   = 4'd11,
    S_LINK   = 4'd12,
    S_BRV    = 4'd13,
    S_JUMP   = 4'd14
  } state_e;

  function automatic logic op_known(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_J) || (op == OP_IMM) || (op == OP_BLEZAL) || (op == OP_BRV);
  endfunction

endpackage

// File: rtl/mcontrol_outdec.sv
// Combinational output decode of the controller state; the only input-dependent
// terms are mem_ready in FETCH, the branch flags in pcen and the opcode check in DECODE.
module mcontrol_outdec
  import mcontrol_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic [5:0] i_op,
  input  logic       i_mem_ready,
  input  logic       i_zero,
  input  logic       i_alu_neg,
  input  logic       i_taken_q,
  output logic       o_pcen,
  output logic       o_iord,
  output logic       o_memread,
  output logic       o_memwrite,
  output logic       o_irwrite,
  output logic       o_memtoreg,
  output logic       o_regdst,
  output logic       o_link,
  output logic       o_regwrite,
  output logic       o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic [1:0] o_pcsource,
  output logic [2:0] o_aluop,
  output logic       o_illegal
);

  always_comb begin
    o_pcen     = 1'b0;
    o_iord     = 1'b0;
    o_memread  = 1'b0;
    o_memwrite = 1'b0;
    o_irwrite  = 1'b0;
    o_memtoreg = 1'b0;
    o_regdst   = 1'b0;
    o_link     = 1'b0;
    o_regwrite = 1'b0;
    o_alusrca  = 1'b0;
    o_alusrcb  = SRCB_B;
    o_pcsource = PCS_ALU;
    o_aluop    = ALUOP_ADD;
    o_illegal  = 1'b0;
    case (i_state)
      S_FETCH: begin
        o_memread = 1'b1;
        o_alusrcb = SRCB_4;
        o_irwrite = i_mem_ready;
        o_pcen    = i_mem_ready;
      end
      S_DECODE: begin
        o_alusrcb = SRCB_IMMSH;
        o_illegal = !op_known(i_op);
      end
      S_MEMADR: begin
        o_alusrca = 1'b1;
        o_alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        o_memread = 1'b1;
        o_iord    = 1'b1;
      end
      S_MEMWB: begin
        o_regwrite = 1'b1;
        o_memtoreg = 1'b1;
      end
      S_MEMWR: begin
        o_memwrite = 1'b1;
        o_iord     = 1'b1;
      end
      S_RTEXEC: begin
        o_alusrca = 1'b1;
        o_aluop   = ALUOP_RT;
      end
      S_RTWB: begin
        o_regwrite = 1'b1;
        o_regdst   = 1'b1;
      end
      S_ITEXEC: begin
        o_alusrca = 1'b1;
        o_alusrcb = SRCB_IMM;
        o_aluop   = ALUOP_IMM;
      end
      S_ITWB: o_regwrite = 1'b1;
      S_BEQ, S_BLEZ: begin
        o_alusrca  = 1'b1;
        o_aluop    = ALUOP_SUB;
        o_pcsource = PCS_ALUOUT;
        o_pcen     = (i_state == S_BEQ) ? i_zero : (i_zero | i_alu_neg);
      end
      // LINK is only reachable after a taken blezal; taken_q keeps it that way.
      S_LINK: begin
        o_regwrite = i_taken_q;
        o_link     = i_taken_q;
      end
      S_BRV: begin
        o_alusrca  = 1'b1;
        o_aluop    = ALUOP_BRV;
        o_pcsource = PCS_A;
        o_pcen     = 1'b1;
      end
      S_JUMP: begin
        o_pcsource = PCS_JUMP;
        o_pcen     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mcontrol_fsm.sv
// Multicycle MIPS-subset main control: state register, next-state sequencing and
// blezal taken flag; reset forces every output low in the same cycle.
module mcontrol_fsm
  import mcontrol_pkg::*;
#(
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_op,
  input  logic       i_zero,
  input  logic       i_alu_neg,
  input  logic       i_mem_ready,
  output logic       o_pcen,
  output logic       o_iord,
  output logic       o_memread,
  output logic       o_memwrite,
  output logic       o_irwrite,
  output logic       o_memtoreg,
  output logic       o_regdst,
  output logic       o_link,
  output logic [4:0] o_link_rd,
  output logic       o_regwrite,
  output logic       o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic [1:0] o_pcsource,
  output logic       o_aluop2,
  output logic       o_aluop1,
  output logic       o_aluop0,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  state_e     r_state;
  logic       r_taken_q;
  logic       w_taken;
  logic       w_pcen, w_iord, w_memread, w_memwrite, w_irwrite, w_memtoreg;
  logic       w_regdst, w_link, w_regwrite, w_alusrca, w_illegal;
  logic [1:0] w_alusrcb, w_pcsource;
  logic [2:0] w_aluop;

  assign w_taken = i_zero | i_alu_neg;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_FETCH;
      r_taken_q <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:  if (i_mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (i_op)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_R:         r_state <= S_RTEXEC;
            OP_IMM:       r_state <= S_ITEXEC;
            OP_BEQ:       r_state <= S_BEQ;
            OP_BLEZAL:    r_state <= S_BLEZ;
            OP_BRV:       r_state <= S_BRV;
            OP_J:         r_state <= S_JUMP;
            default:      r_state <= S_FETCH;
          endcase
        end
        S_MEMADR: r_state <= (i_op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (i_mem_ready) r_state <= S_MEMWB;
        S_MEMWR:  if (i_mem_ready) r_state <= S_FETCH;
        S_RTEXEC: r_state <= S_RTWB;
        S_ITEXEC: r_state <= S_ITWB;
        S_BLEZ: begin
          r_taken_q <= w_taken;
          r_state   <= w_taken ? S_LINK : S_FETCH;
        end
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  mcontrol_outdec u_outdec (
    .i_state     (r_state),
    .i_op        (i_op),
    .i_mem_ready (i_mem_ready),
    .i_zero      (i_zero),
    .i_alu_neg   (i_alu_neg),
    .i_taken_q   (r_taken_q),
    .o_pcen      (w_pcen),
    .o_iord      (w_iord),
    .o_memread   (w_memread),
    .o_memwrite  (w_memwrite),
    .o_irwrite   (w_irwrite),
    .o_memtoreg  (w_memtoreg),
    .o_regdst    (w_regdst),
    .o_link      (w_link),
    .o_regwrite  (w_regwrite),
    .o_alusrca   (w_alusrca),
    .o_alusrcb   (w_alusrcb),
    .o_pcsource  (w_pcsource),
    .o_aluop     (w_aluop),
    .o_illegal   (w_illegal)
  );

  // Reset must silence the datapath immediately, even mid-instruction.
  assign o_pcen     = w_pcen     & ~i_reset;
  assign o_iord     = w_iord     & ~i_reset;
  assign o_memread  = w_memread  & ~i_reset;
  assign o_memwrite = w_memwrite & ~i_reset;
  assign o_irwrite  = w_irwrite  & ~i_reset;
  assign o_memtoreg = w_memtoreg & ~i_reset;
  assign o_regdst   = w_regdst   & ~i_reset;
  assign o_link     = w_link     & ~i_reset;
  assign o_regwrite = w_regwrite & ~i_reset;
  assign o_alusrca  = w_alusrca  & ~i_reset;
  assign o_illegal  = w_illegal  & ~i_reset;
  assign o_alusrcb  = i_reset ? 2'b00 : w_alusrcb;
  assign o_pcsource = i_reset ? 2'b00 : w_pcsource;
  assign o_aluop2   = w_aluop[2] & ~i_reset;
  assign o_aluop1   = w_aluop[1] & ~i_reset;
  assign o_aluop0   = w_aluop[0] & ~i_reset;
  assign o_link_rd  = i_reset ? 5'd0 : LINK_REG;
  assign o_state    = i_reset ? 4'd0 : r_state;

endmodule

// File: tb/tb_mcontrol_fsm.sv
// Bench for mcontrol_fsm: each instruction is expanded into its expected per-cycle
// trace from the opcode's documented flow, then replayed against the design.
module tb_mcontrol_fsm;
  import mcontrol_pkg::*;

  typedef struct packed {
    logic       pcen, iord, memread, memwrite, irwrite, memtoreg, regdst, link, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic [2:0] aluop;
    logic       illegal;
  } outs_t;

  typedef struct {
    logic [3:0] st;
    outs_t      o;
    logic       mr, z, n;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, zero, alu_neg, mem_ready;
  logic [5:0] op;
  logic       pcen, iord, memread, memwrite, irwrite, memtoreg, regdst, link, regwrite, alusrca;
  logic       aluop2, aluop1, aluop0, illegal;
  logic [1:0] alusrcb, pcsource;
  logic [4:0] link_rd;
  logic [3:0] state;
  outs_t      obs;
  exp_t       q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  mcontrol_fsm dut (
    .i_clk(clk), .i_reset(reset), .i_op(op), .i_zero(zero), .i_alu_neg(alu_neg),
    .i_mem_ready(mem_ready), .o_pcen(pcen), .o_iord(iord), .o_memread(memread),
    .o_memwrite(memwrite), .o_irwrite(irwrite), .o_memtoreg(memtoreg), .o_regdst(regdst),
    .o_link(link), .o_link_rd(link_rd), .o_regwrite(regwrite), .o_alusrca(alusrca),
    .o_alusrcb(alusrcb), .o_pcsource(pcsource), .o_aluop2(aluop2), .o_aluop1(aluop1),
    .o_aluop0(aluop0), .o_illegal(illegal), .o_state(state)
  );

  assign obs = {pcen, iord, memread, memwrite, irwrite, memtoreg, regdst, link, regwrite,
                alusrca, alusrcb, pcsource, aluop2, aluop1, aluop0, illegal};

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic legal(input logic [5:0] o);
    return o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                     6'b000010, 6'b001101, 6'b010110, 6'b010100};
  endfunction

  task automatic push(input logic [3:0] st, input outs_t o, input logic mr, input logic z,
                      input logic n);
    exp_t e;
    e.st = st; e.o = o; e.mr = mr; e.z = z; e.n = n;
    q.push_back(e);
  endtask

  // Expected trace: fw stalled FETCH cycles, mw stalled memory cycles, z/n in the branch cycle.
  task automatic build(input logic [5:0] opc, input int fw, input int mw, input logic z,
                       input logic n);
    outs_t o;
    q.delete();
    o = '0; o.memread = 1'b1; o.alusrcb = 2'b01;
    for (int i = 0; i < fw; i++) push(S_FETCH, o, 1'b0, rb(), rb());
    o.irwrite = 1'b1; o.pcen = 1'b1;
    push(S_FETCH, o, 1'b1, rb(), rb());
    o = '0; o.alusrcb = 2'b11; o.illegal = !legal(opc);
    push(S_DECODE, o, rb(), rb(), rb());
    case (opc)
      6'b100011, 6'b101011: begin
        o = '0; o.alusrca = 1'b1; o.alusrcb = 2'b10;
        push(S_MEMADR, o, rb(), rb(), rb());
        o = '0; o.iord = 1'b1;
        if (opc == 6'b100011) begin
          o.memread = 1'b1;
          for (int i = 0; i < mw; i++) push(S_MEMRD, o, 1'b0, rb(), rb());
          push(S_MEMRD, o, 1'b1, rb(), rb());
          o = '0; o.regwrite = 1'b1; o.memtoreg = 1'b1;
          push(S_MEMWB, o, rb(), rb(), rb());
        end else begin
          o.memwrite = 1'b1;
          for (int i = 0; i < mw; i++) push(S_MEMWR, o, 1'b0, rb(), rb());
          push(S_MEMWR, o, 1'b1, rb(), rb());
        end
      end
      6'b000000: begin
        o = '0; o.alusrca = 1'b1; o.aluop = 3'b100;
        push(S_RTEXEC, o, rb(), rb(), rb());
        o = '0; o.regwrite = 1'b1; o.regdst = 1'b1;
        push(S_RTWB, o, rb(), rb(), rb());
      end
      6'b001101: begin
        o = '0; o.alusrca = 1'b1; o.alusrcb = 2'b10; o.aluop = 3'b011;
        push(S_ITEXEC, o, rb(), rb(), rb());
        o = '0; o.regwrite = 1'b1;
        push(S_ITWB, o, rb(), rb(), rb());
      end
      6'b000100, 6'b010110: begin
        o = '0; o.alusrca = 1'b1; o.aluop = 3'b001; o.pcsource = 2'b01;
        o.pcen = (opc == 6'b000100) ? z : (z | n);
        push((opc == 6'b000100) ? S_BEQ : S_BLEZ, o, rb(), z, n);
        if (opc == 6'b010110 && (z | n)) begin
          o = '0; o.regwrite = 1'b1; o.link = 1'b1;
          push(S_LINK, o, rb(), rb(), rb());
        end
      end
      6'b010100: begin
        o = '0; o.alusrca = 1'b1; o.aluop = 3'b111; o.pcsource = 2'b11; o.pcen = 1'b1;
        push(S_BRV, o, rb(), rb(), rb());
      end
      6'b000010: begin
        o = '0; o.pcsource = 2'b10; o.pcen = 1'b1;
        push(S_JUMP, o, rb(), rb(), rb());
      end
      default: ;
    endcase
  endtask

  task automatic replay(input logic [5:0] opc, input int n_steps);
    for (int i = 0; i < n_steps && i < q.size(); i++) begin
      @(posedge clk); #1;
      reset = 1'b0; op = opc; mem_ready = q[i].mr; zero = q[i].z; alu_neg = q[i].n;
      #2;
      n_checks++;
      assert (state === q[i].st) else begin
        n_fail++;
        $error("FAIL state op=%b step %0d: observed %0d expected %0d", opc, i, state, q[i].st);
      end
      n_checks++;
      assert (obs === q[i].o) else begin
        n_fail++;
        $error("FAIL outputs op=%b step %0d: observed %h expected %h", opc, i, obs, q[i].o);
      end
      n_checks++;
      assert (link_rd === 5'd31) else begin
        n_fail++;
        $error("FAIL link_rd op=%b step %0d: observed %0d expected 31", opc, i, link_rd);
      end
    end
  endtask

  task automatic run(input logic [5:0] opc, input int fw, input int mw, input logic z,
                     input logic n);
    build(opc, fw, mw, z, n);
    replay(opc, q.size());
  endtask

  task automatic reset_cycles(input int cycles, input logic mr);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      reset = 1'b1; mem_ready = mr; zero = rb(); alu_neg = rb();
      #2;
      n_checks++;
      assert ({state, obs, link_rd} === '0) else begin
        n_fail++;
        $error("FAIL reset_outputs cycle %0d: observed state=%0d outs=%h link_rd=%0d expected 0",
               i, state, obs, link_rd);
      end
    end
  endtask

  initial begin
    logic [5:0] ops [8];
    logic [5:0] ropc;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
            6'b000010, 6'b001101, 6'b010110, 6'b010100};
    reset = 1'b1; op = 6'd0; zero = 1'b0; alu_neg = 1'b0; mem_ready = 1'b0;
    reset_cycles(2, 1'b1);

    run(6'b100011, 2, 1, 1'b0, 1'b0);   // lw with fetch and read stalls
    run(6'b000000, 0, 0, 1'b0, 1'b0);   // R-type
    run(6'b010110, 0, 0, 1'b0, 1'b1);   // blezal taken via negative
    run(6'b010110, 0, 0, 1'b0, 1'b0);   // blezal not taken
    run(6'b010110, 1, 0, 1'b1, 1'b0);   // blezal taken via zero
    run(6'b010100, 0, 0, 1'b0, 1'b0);   // brv
    run(6'b000100, 0, 0, 1'b0, 1'b1);   // beq not taken
    run(6'b000100, 0, 0, 1'b1, 1'b0);   // beq taken
    run(6'b111111, 0, 0, 1'b0, 1'b0);   // illegal opcode
    run(6'b101011, 0, 2, 1'b0, 1'b0);   // sw with write stalls
    run(6'b001101, 0, 0, 1'b0, 1'b0);   // imm-op
    run(6'b000010, 0, 0, 1'b0, 1'b0);   // j

    // Reset while a store is stalled in MEMWR.
    build(6'b101011, 0, 3, 1'b0, 1'b0);
    replay(6'b101011, 4);
    reset_cycles(1, 1'b0);

    for (int k = 0; k < 60; k++) begin
      ropc = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
      run(ropc, $urandom_range(0, 2), $urandom_range(0, 2), rb(), rb());
    end

    build(6'b000010, 0, 0, 1'b0, 1'b0);
    replay(6'b000010, 1);
    reset_cycles(1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
